// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// sequencer states and the fixed divider iteration count.
package muldiv_ctrl_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MULT,
    MULTU,
    DIV,
    DIVU,
    NONE
  } mult_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  function automatic logic [31:0] absVal(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, and shift the resulting quotient bit in.
module div_step (
  input  logic [32:0] remIn,
  input  logic [31:0] quoIn,
  input  logic [31:0] divisor,
  output logic [32:0] remOut,
  output logic [31:0] quoOut
);

  logic [33:0] remShift;

  always_comb begin
    remShift = {remIn, quoIn[31]};
    if (remShift >= {2'b00, divisor}) begin
      remOut = 33'(remShift - {2'b00, divisor});
      quoOut = {quoIn[30:0], 1'b1};
    end else begin
      remOut = remShift[32:0];
      quoOut = {quoIn[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: stalls the issuing stage while
// busy and pulses the HI/LO write strobes once the result is ready.
module muldiv_ctrl #(
  parameter int DIV_ITERS = muldiv_ctrl_pkg::DIV_ITERS,
  parameter int MUL_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  muldiv_ctrl_pkg::mult_t op,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic                   flush,
  output logic                   stall,
  output logic                   done,
  output logic                   hi_write,
  output logic                   lo_write,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic [1:0]             dbgState
);
  import muldiv_ctrl_pkg::*;

  // Handshake: the requester holds start (and stable operands) until it sees
  // done; a request is taken only in IDLE without flush, done is a one-cycle
  // pulse and start is ignored while busy and during the done cycle.

  muldiv_state_t stateQ, stateD;
  mult_t         opQ;
  logic [31:0]   aQ, bQ, quoQ, divisorQ, hiQ, loQ;
  logic [32:0]   remQ, remNext;
  logic [31:0]   quoNext, quoFix, remFix;
  logic [63:0]   prodQ, mulProd;
  logic [32:0]   mulA, mulB;
  logic [5:0]    cntQ;
  logic          signA, signB;
  logic          isMulOp, isDivOp, accept;

  assign isMulOp = (op == MULT) || (op == MULTU);
  assign isDivOp = (op == DIV) || (op == DIVU);
  assign accept  = (stateQ == ST_IDLE) && start && !flush && (isMulOp || isDivOp);

  // 33-bit operands let one signed multiplier cover both MULT and MULTU.
  assign mulA    = {(opQ == MULT) & aQ[31], aQ};
  assign mulB    = {(opQ == MULT) & bQ[31], bQ};
  assign mulProd = 64'($signed(mulA)) * 64'($signed(mulB));

  div_step u_div_step (
    .remIn  (remQ),
    .quoIn  (quoQ),
    .divisor(divisorQ),
    .remOut (remNext),
    .quoOut (quoNext)
  );

  assign quoFix = (signA ^ signB) ? -quoNext : quoNext;
  assign remFix = signA ? -remNext[31:0] : remNext[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= ST_IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    stall  = 1'b0;
    done   = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (accept) begin
          stall  = 1'b1;
          stateD = isMulOp ? ST_MUL : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        stall = 1'b1;
        if (cntQ == 6'd0) stateD = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        stateD = ST_IDLE;
      end
      default: stateD = ST_IDLE;
    endcase
    if (flush) begin
      stateD = ST_IDLE;
      done   = 1'b0;
    end
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opQ      <= NONE;
      aQ       <= '0;
      bQ       <= '0;
      quoQ     <= '0;
      divisorQ <= '0;
      remQ     <= '0;
      prodQ    <= '0;
      cntQ     <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (accept) begin
            opQ      <= op;
            aQ       <= a;
            bQ       <= b;
            signA    <= (op == DIV) & a[31];
            signB    <= (op == DIV) & b[31];
            quoQ     <= (op == DIV) ? absVal(a) : a;
            divisorQ <= (op == DIV) ? absVal(b) : b;
            remQ     <= '0;
            cntQ     <= isMulOp ? 6'(MUL_LAT - 1) : 6'(DIV_ITERS - 1);
          end
        end
        ST_MUL: begin
          if (!flush) begin
            prodQ <= mulProd;
            if (cntQ == 6'd0) {hiQ, loQ} <= (MUL_LAT == 1) ? mulProd : prodQ;
            else              cntQ <= cntQ - 6'd1;
          end
        end
        ST_DIV: begin
          if (!flush) begin
            remQ <= remNext;
            quoQ <= quoNext;
            if (cntQ != 6'd0) begin
              cntQ <= cntQ - 6'd1;
            end else if (bQ == 32'd0) begin
              // Divide by zero reports the raw dividend, no sign fixup.
              hiQ <= aQ;
              loQ <= 32'hFFFF_FFFF;
            end else begin
              hiQ <= remFix;
              loQ <= quoFix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hiQ;
  assign lo       = loQ;
  assign hi_write = done;
  assign lo_write = done;
  assign dbgState = stateQ;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random
// requests, checked against an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  mult_t       op;
  logic [31:0] a, b, hi, lo;
  logic        stall, done, hi_write, lo_write;
  logic [1:0]  dbgState;

  int          errCnt = 0;
  int          chkCnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  // clock / reset
  always #5 clk = ~clk;

  muldiv_ctrl #(.DIV_ITERS(DIV_ITERS), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .hi_write(hi_write),
    .lo_write(lo_write),
    .hi      (hi),
    .lo      (lo),
    .dbgState(dbgState)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chkCnt++;
    if (obs !== expv) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference result as {hi, lo}, straight from the arithmetic definition.
  function automatic logic [63:0] refModel(input mult_t o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ix = int'(x);
    iy = int'(y);
    case (o)
      MULT:  return 64'(sx * sy);
      MULTU: return ux * uy;
      DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ix % iy), 32'(ix / iy)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // driver: called shortly after a rising edge; issues one request and
  // follows it to completion.
  task automatic runOp(input mult_t o, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic        seen;
    logic [63:0] expv;
    lat = (o == MULT || o == MULTU) ? MUL_LAT + 1 : DIV_ITERS + 1;
    exp_q.push_back(refModel(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    #1 checkVal("accept_stall", stall, 1);
    seen = 1'b0;
    for (int cyc = 1; cyc <= lat + 4; cyc++) begin
      @(posedge clk); #2;
      if (done) begin
        seen = 1'b1;
        expv = exp_q.pop_front();
        checkVal("latency", cyc, lat);
        checkVal("hi", hi, expv[63:32]);
        checkVal("lo", lo, expv[31:0]);
        checkVal("hi_write", hi_write, 1);
        checkVal("lo_write", lo_write, 1);
        checkVal("done_stall", stall, 0);
        lastHi = expv[63:32];
        lastLo = expv[31:0];
        break;
      end else begin
        checkVal("busy_stall", stall, 1);
      end
    end
    if (!seen) begin
      checkVal("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    // start stays high across the done edge, then the requester drops it
    @(posedge clk); #1;
    start = 1'b0;
    #1 checkVal("idle_stall", stall, 0);
    repeat (3) begin
      @(posedge clk); #2;
      checkVal("no_retrigger", done, 0);
      checkVal("no_hi_write", hi_write, 0);
    end
  endtask

  initial begin
    mult_t       ro;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = NONE; a = '0; b = '0;
    #12;
    checkVal("rst_stall", stall, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_hi", hi, 0);
    checkVal("rst_lo", lo, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    runOp(MULT, 32'hFFFF_FFFE, 32'd3);
    runOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp(DIV, 32'hFFFF_FFF9, 32'd2);
    runOp(DIVU, 32'd100, 32'd7);
    runOp(DIVU, 32'd5, 32'd0);
    runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(DIV, 32'd9, 32'd0);

    // flush during a divide
    op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    #1 checkVal("flush_accept_stall", stall, 1);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    #1 checkVal("flush_div_done", done, 0);
    @(posedge clk); #1 flush = 1'b0;
    #1;
    checkVal("flush_idle", dbgState, 0);
    checkVal("flush_stall", stall, 0);
    checkVal("flush_done_after", done, 0);
    checkVal("flush_hi_keep", hi, lastHi);
    checkVal("flush_lo_keep", lo, lastLo);
    runOp(MULT, 32'd6, 32'd7);

    // flush landing on the done cycle suppresses the strobes
    op = MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    repeat (MUL_LAT + 1) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    checkVal("flush_on_done", done, 0);
    checkVal("flush_on_done_hiw", hi_write, 0);
    checkVal("flush_on_done_low", lo_write, 0);
    start = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    #1 checkVal("flush_on_done_idle", dbgState, 0);
    runOp(MULTU, 32'd12345, 32'd678);

    // asynchronous reset in the middle of a divide
    op = DIV; a = 32'd1234567; b = 32'd89; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkVal("arst_stall", stall, 0);
    checkVal("arst_done", done, 0);
    checkVal("arst_hi", hi, 0);
    checkVal("arst_lo", lo, 0);
    checkVal("arst_state", dbgState, 0);
    start = 1'b0;
    @(negedge clk) reset = 1'b0;
    lastHi = '0; lastLo = '0;
    @(posedge clk); #1;
    checkVal("arst_release_idle", dbgState, 0);

    // randomized requests
    for (int n = 0; n < 16; n++) begin
      ro = mult_t'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 16));
        default: ry = $urandom;
      endcase
      runOp(ro, rx, ry);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer sitting beside the execute stage. It accepts MULT/MULTU/DIV/DIVU requests, runs a 2-cycle multiplier or a 32-iteration restoring divider, and drives the pipeline stall until the result is ready. It then issues a one-cycle HI/LO write strobe to the hilo register file. Exceptions and ERET squash an in-flight operation.

## Interface
Parameters:
- DIV_ITERS, 32, number of divider iterations; fixed at 32 for 32-bit operands.
- MUL_LAT, 2, multiplier latency in cycles; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request valid; the requester holds it high, with stable operands, until `done`.
- op  in  mult_t  MULT, MULTU, DIV or DIVU; sampled only when a request is accepted.
- a  in  32  rs operand; dividend for divides.
- b  in  32  rt operand; divisor for divides.
- flush  in  1  exception/ERET; aborts the current operation.
- stall  out  1  hold the issuing stage.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- hi_write  out  1  equals `done`.
- lo_write  out  1  equals `done`.
- hi  out  32  HI result.
- lo  out  32  LO result.

## Operation
- States are IDLE, MUL, DIV and DONE. Reset value is IDLE.
- Output reset values: stall=0, done=0, hi=0, lo=0.
- IDLE & start & ~flush:
  - Latch op, a and b.
  - For divides, latch |a|, |b| and both sign bits.
  - Go to MUL with counter=MUL_LAT-1, or to DIV with counter=DIV_ITERS-1.
- MUL:
  - Product is a 64-bit signed (MULT) or unsigned (MULTU) multiply of the latched operands.
  - The product is registered.
  - When counter=0, go to DONE with {hi,lo}=product. Otherwise decrement the counter.
- DIV: one restoring step per cycle.
  - Working values are a 33-bit partial remainder and a 32-bit quotient shift register.
  - When counter=0, apply signs: quotient negated if sign_a^sign_b (signed only); remainder negated if sign_a (signed only).
  - Load lo=quotient and hi=remainder, then go to DONE.
- DONE:
  - Assert done, hi_write and lo_write for exactly one cycle.
  - Return to IDLE unconditionally.
  - start is ignored in this cycle; the requester drops start once it has advanced.
- Divide by zero:
  - Runs the full 32 cycles.
  - Result is lo=32'hFFFF_FFFF and hi=a, both unsigned-raw with no sign fixup.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo=32'h8000_0000, hi=0.
- flush in any state:
  - Next state is IDLE.
  - done is forced to 0 in the same cycle; no HI/LO write occurs.
  - hi/lo keep their previous values.
- start arriving while in MUL or DIV is ignored; the operation in progress is not restarted.
- hi/lo hold their value from DONE until the next DONE.

## Timing
- stall = (IDLE & start & ~flush) | MUL | DIV. It is combinational so the issuing stage holds in the acceptance cycle.
- stall=0 in DONE and IDLE without start.
- If start is accepted at cycle t:
  - Multiply: done at t+MUL_LAT+1, i.e. t+3 by default.
  - Divide: done at t+DIV_ITERS+1, i.e. t+33.
- stall is high from cycle t through the cycle before done, inclusive.
- flush and done can never coincide: flush wins and suppresses done.
- Back-to-back requests: a new start is accepted no earlier than the IDLE cycle after DONE.
- Asynchronous reset mid-operation returns to IDLE immediately and clears all outputs.

## Structure
- mult_t (MULT, MULTU, DIV, DIVU, NONE) lives in the shared defs package.
- The muldiv state enum and DIV_ITERS also live in the shared defs package.
- One sub-module, `div_step`: purely combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and next quotient.
  - The iteration counter stays in `muldiv_ctrl`.
- The multiplier is inline: a `*` on sign-/zero-extended 33-bit operands, followed by a pipeline register.

## Test plan
- MULT a=32'hFFFF_FFFE (−2), b=3: stall high for cycles t..t+2; done at t+3; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF: hi=32'hFFFF_FFFE, lo=1; hi_write=lo_write=1 for one cycle only.
- Signed divides, done at t+33:
  - DIV a=−7, b=2: lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFF (−1).
  - DIVU a=100, b=7: lo=14, hi=2.
- DIVU a=5, b=0: lo=32'hFFFF_FFFF, hi=5 after 33 cycles; then DIV 32'h8000_0000 / −1 gives lo=32'h8000_0000, hi=0.
- Flush during DIV at t+10: IDLE next cycle, no done, hi/lo unchanged; a new MULT of 6×7 issued immediately gives lo=42 at its t+3.
- Asynchronous reset asserted mid-DIV: stall, done, hi and lo all 0 without waiting for a clock edge. start held through DONE does not retrigger; exactly one done per request.
